// File: rtl/filter_ctrl_pkg.sv
// Shared types and default geometry for the 3x3 filter sequencer.
package filter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

endpackage

// File: rtl/filter_pos_cnt.sv
// Wrapping position counter: counts 0..LAST, with a clear that may also count the current event.
module filter_pos_cnt #(
  parameter int W    = 4,
  parameter int LAST = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = (cnt == W'(LAST));

  // NOTE: state resets asynchronously on the low level and updates with non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/filter_frame_ctrl.sv
// Pixel-position sequencer for the 3x3 filter core: line-buffer/window strobes,
// line-end advance, bottom-row flush, border flags and output framing.
module filter_frame_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             frame_i,
  output logic             pix_we,
  output logic [COL_W-1:0] lb_addr,
  output logic             adv,
  output logic             lb_rot,
  output logic [COL_W-1:0] ctr_col,
  output logic [ROW_W-1:0] ctr_row,
  output logic             brd_left,
  output logic             brd_right,
  output logic             brd_top,
  output logic             brd_bot,
  output logic             valid_o,
  output logic             frame_o,
  output logic             busy,
  output logic             err
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  // Flush column runs 0..IMG_W, one past the last real column.
  localparam int FL_W = COL_W + 1;

  typedef struct packed {
    logic             pix_we;
    logic [COL_W-1:0] lb_addr;
    logic             adv;
    logic             lb_rot;
    logic [COL_W-1:0] ctr_col;
    logic [ROW_W-1:0] ctr_row;
    logic             brd_left;
    logic             brd_right;
    logic             brd_top;
    logic             brd_bot;
    logic             valid;
    logic             frame;
  } strobe_t;

  state_t           state, state_nxt;
  logic             lend, lend_nxt;
  logic [ROW_W-1:0] row_in, row_nxt;
  logic             err_set;
  strobe_t          s, s_q;

  logic [COL_W-1:0] col_in;
  logic             col_wrap, col_clr, col_inc;
  logic [FL_W-1:0]  fl_k;
  logic             fl_done, fl_clr, fl_inc;

  filter_pos_cnt #(.W(COL_W), .LAST(IMG_W - 1)) u_col_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (col_clr),
    .inc   (col_inc),
    .cnt   (col_in),
    .wrap  (col_wrap)
  );

  filter_pos_cnt #(.W(FL_W), .LAST(IMG_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (fl_clr),
    .inc   (fl_inc),
    .cnt   (fl_k),
    .wrap  (fl_done)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    s         = '0;
    state_nxt = state;
    lend_nxt  = 1'b0;
    row_nxt   = row_in;
    col_clr   = 1'b0;
    col_inc   = 1'b0;
    fl_clr    = 1'b0;
    fl_inc    = 1'b0;
    err_set   = 1'b0;

    case (state)
      IDLE: begin
        if (valid_i && frame_i) begin
          s.pix_we  = 1'b1;
          col_clr   = 1'b1;
          col_inc   = 1'b1;
          row_nxt   = '0;
          state_nxt = FILL;
        end
      end

      FILL, RUN: begin
        if (lend) begin
          // Line end wins over any input; a pixel here breaks the blanking rule.
          s.adv     = 1'b1;
          s.lb_rot  = 1'b1;
          s.ctr_col = COL_LAST;
          s.ctr_row = (state == RUN) ? row_in - ROW_W'(1) : '0;
          s.valid   = (state == RUN);
          err_set   = valid_i;
          if (row_in == ROW_LAST) begin
            state_nxt = FLUSH;
            fl_clr    = 1'b1;
            row_nxt   = '0;
          end else begin
            state_nxt = RUN;
            row_nxt   = row_in + ROW_W'(1);
          end
        end else if (valid_i && frame_i) begin
          err_set   = 1'b1;
          s.pix_we  = 1'b1;
          col_clr   = 1'b1;
          col_inc   = 1'b1;
          row_nxt   = '0;
          state_nxt = FILL;
        end else if (valid_i) begin
          s.pix_we  = 1'b1;
          s.lb_addr = col_in;
          col_inc   = 1'b1;
          lend_nxt  = col_wrap;
          if (col_in != '0) begin
            s.adv     = 1'b1;
            s.ctr_col = col_in - COL_W'(1);
            s.ctr_row = (state == RUN) ? row_in - ROW_W'(1) : '0;
            s.valid   = (state == RUN);
          end
        end
      end

      FLUSH: begin
        err_set = valid_i;
        fl_inc  = 1'b1;
        if (!fl_done) begin
          s.pix_we  = 1'b1;
          s.lb_addr = fl_k[COL_W-1:0];
        end
        if (fl_k != '0) begin
          s.adv     = 1'b1;
          s.valid   = 1'b1;
          s.ctr_col = COL_W'(fl_k - FL_W'(1));
          s.ctr_row = ROW_LAST;
        end
        if (fl_done) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    s.brd_left  = s.adv && (s.ctr_col == '0);
    s.brd_right = s.adv && (s.ctr_col == COL_LAST);
    s.brd_top   = s.adv && (s.ctr_row == '0);
    s.brd_bot   = s.adv && (s.ctr_row == ROW_LAST);
    s.frame     = s.valid && (s.ctr_col == '0) && (s.ctr_row == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      lend   <= 1'b0;
      row_in <= '0;
      s_q    <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      lend   <= lend_nxt;
      row_in <= row_nxt;
      s_q    <= s;
      busy   <= (state != IDLE);
      err    <= err | err_set;
    end
  end

  assign pix_we    = s_q.pix_we;
  assign lb_addr   = s_q.lb_addr;
  assign adv       = s_q.adv;
  assign lb_rot    = s_q.lb_rot;
  assign ctr_col   = s_q.ctr_col;
  assign ctr_row   = s_q.ctr_row;
  assign brd_left  = s_q.brd_left;
  assign brd_right = s_q.brd_right;
  assign brd_top   = s_q.brd_top;
  assign brd_bot   = s_q.brd_bot;
  assign valid_o   = s_q.valid;
  assign frame_o   = s_q.frame;

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Randomized self-checking bench for filter_frame_ctrl on a 4x3 image; expectations come from
// a raster-order model of when each centre pixel becomes computable.
module tb_filter_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic          clock = 1'b0;
  logic          reset, valid_i, frame_i;
  logic          pix_we, adv, lb_rot, brd_left, brd_right, brd_top, brd_bot;
  logic          valid_o, frame_o, busy, err;
  logic [CW-1:0] lb_addr, ctr_col;
  logic [RW-1:0] ctr_row;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  filter_frame_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clock     (clock),
    .reset     (reset),
    .valid_i   (valid_i),
    .frame_i   (frame_i),
    .pix_we    (pix_we),
    .lb_addr   (lb_addr),
    .adv       (adv),
    .lb_rot    (lb_rot),
    .ctr_col   (ctr_col),
    .ctr_row   (ctr_row),
    .brd_left  (brd_left),
    .brd_right (brd_right),
    .brd_top   (brd_top),
    .brd_bot   (brd_bot),
    .valid_o   (valid_o),
    .frame_o   (frame_o),
    .busy      (busy),
    .err       (err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; int row; int col; bit fo, bl, br, bt, bb; } got_t;
  typedef struct { int cyc; int row; int col; } exp_t;

  got_t got_q[$];
  exp_t exp_q[$];
  int   rot_q[$], exp_rot[$], we_q[$], exp_we[$];
  int   err_first, busy_first, busy_last, fo_cnt;

  // Observer: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (valid_o)
      got_q.push_back('{cyc, int'(ctr_row), int'(ctr_col), frame_o, brd_left, brd_right, brd_top, brd_bot});
    if (frame_o) fo_cnt++;
    if (lb_rot) rot_q.push_back(cyc);
    if (pix_we) we_q.push_back(int'(lb_addr));
    if (err && err_first < 0) err_first = cyc;
    if (busy) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
  end

  task automatic clear_mon();
    got_q.delete(); exp_q.delete(); rot_q.delete(); exp_rot.delete();
    we_q.delete(); exp_we.delete();
    err_first = -1; busy_first = -1; busy_last = -1; fo_cnt = 0;
  endtask

  // Drive one input cycle; e is the index of the clock edge that samples it.
  task automatic drive(input bit v, input bit f, output int e);
    @(negedge clock);
    valid_i = v;
    frame_i = f;
    e = cyc + 1;
  endtask

  task automatic idle(input int n);
    int e;
    repeat (n) drive(1'b0, 1'b0, e);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; valid_i = 1'b0; frame_i = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Drives a full frame and fills the model: centre (r-1,c-1) is computable once pixel (r,c)
  // arrives, the last column of a line on the line-end cycle, the bottom row during the flush.
  task automatic drive_frame(input int max_gap, input int max_extra, output int e_first, output int e_last);
    int e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        repeat ($urandom_range(max_gap, 0)) drive(1'b0, 1'b0, e);
        drive(1'b1, (r == 0 && c == 0), e);
        if (r == 0 && c == 0) e_first = e;
        exp_we.push_back(c);
        if (r >= 1 && c >= 1) exp_q.push_back('{e, r - 1, c - 1});
        if (c == W - 1) begin
          if (r >= 1) exp_q.push_back('{e + 1, r - 1, W - 1});
          exp_rot.push_back(e + 1);
          e_last = e;
          drive(1'b0, 1'b0, e);
          if (r < H - 1) repeat ($urandom_range(max_extra, 0)) drive(1'b0, 1'b0, e);
        end
      end
    end
    for (int k = 1; k <= W; k++) begin
      exp_q.push_back('{e_last + 2 + k, H - 1, k - 1});
      exp_we.push_back(k - 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; valid_i = 1'b1; frame_i = 1'b1;
    repeat (3) @(negedge clock);
    n_total++;
    if ({pix_we, lb_addr, adv, lb_rot, ctr_col, ctr_row, brd_left, brd_right, brd_top, brd_bot,
         valid_o, frame_o, busy, err} !== '0)
      $display("FAIL reset_outputs: outputs not all zero during reset (valid_o=%b busy=%b err=%b pix_we=%b)",
               valid_o, busy, err, pix_we);
    else n_pass++;
    valid_i = 1'b0; frame_i = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    clear_mon();
    idle(3);
    n_total++;
    if (busy_first !== -1 || we_q.size() !== 0 || err !== 1'b0)
      $display("FAIL reset_idle: busy_first=%0d pix_we=%0d err=%b, required -1/0/0",
               busy_first, we_q.size(), err);
    else n_pass++;
  endtask

  task automatic test_clean_frame();
    int e_first, e_last, nfo;
    clear_mon();
    drive_frame(0, 0, e_first, e_last);
    idle(W + 5);
    n_total++;
    if (got_q.size() !== W * H) $display("FAIL clean_count: %0d valid_o, required %0d", got_q.size(), W * H);
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (i >= got_q.size())
        $display("FAIL clean_ev%0d: missing, required r%0d c%0d at %0d", i, exp_q[i].row, exp_q[i].col, exp_q[i].cyc);
      else if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].row !== exp_q[i].row || got_q[i].col !== exp_q[i].col)
        $display("FAIL clean_ev%0d: r%0d c%0d at %0d, required r%0d c%0d at %0d", i, got_q[i].row,
                 got_q[i].col, got_q[i].cyc, exp_q[i].row, exp_q[i].col, exp_q[i].cyc);
      else n_pass++;
    end
    nfo = (got_q.size() > 0 && got_q[0].fo) ? 1 : 0;
    n_total++;
    if (fo_cnt !== 1 || nfo !== 1) $display("FAIL clean_frame_o: count %0d first %0d, required 1/1", fo_cnt, nfo);
    else n_pass++;
    n_total++;
    if (rot_q.size() !== H) $display("FAIL clean_rot_count: %0d, required %0d", rot_q.size(), H);
    else begin
      int bad = 0;
      foreach (exp_rot[i]) if (rot_q[i] !== exp_rot[i]) bad++;
      if (bad !== 0) $display("FAIL clean_rot_time: %0d lb_rot pulses off time, required 0", bad);
      else n_pass++;
    end
    n_total++;
    if (we_q.size() !== exp_we.size()) $display("FAIL clean_we_count: %0d, required %0d", we_q.size(), exp_we.size());
    else begin
      int bad = 0;
      foreach (exp_we[i]) if (we_q[i] !== exp_we[i]) bad++;
      if (bad !== 0) $display("FAIL clean_we_addr: %0d wrong lb_addr, required 0", bad);
      else n_pass++;
    end
    n_total++;
    if (busy_first !== e_first + 1 || busy_last !== e_last + 2 + W)
      $display("FAIL clean_busy: high %0d..%0d, required %0d..%0d", busy_first, busy_last, e_first + 1, e_last + 2 + W);
    else n_pass++;
    n_total++;
    if (err_first !== -1) $display("FAIL clean_err: err at %0d, required never", err_first);
    else n_pass++;
  endtask

  task automatic test_borders();
    int e_first, e_last;
    clear_mon();
    drive_frame(3, 3, e_first, e_last);
    idle(W + 5);
    n_total++;
    if (got_q.size() !== exp_q.size()) $display("FAIL brd_count: %0d valid_o, required %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      bit bl, br, bt, bb, fo;
      bl = (exp_q[i].col == 0); br = (exp_q[i].col == W - 1);
      bt = (exp_q[i].row == 0); bb = (exp_q[i].row == H - 1);
      fo = bl && bt;
      n_total++;
      if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].row !== exp_q[i].row || got_q[i].col !== exp_q[i].col ||
          {got_q[i].bl, got_q[i].br, got_q[i].bt, got_q[i].bb, got_q[i].fo} !== {bl, br, bt, bb, fo})
        $display("FAIL brd_ev%0d: r%0d c%0d at %0d lrtbf=%b%b%b%b%b, required r%0d c%0d at %0d lrtbf=%b%b%b%b%b",
                 i, got_q[i].row, got_q[i].col, got_q[i].cyc, got_q[i].bl, got_q[i].br, got_q[i].bt,
                 got_q[i].bb, got_q[i].fo, exp_q[i].row, exp_q[i].col, exp_q[i].cyc, bl, br, bt, bb, fo);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int e_first, e_last, e, nbad;
    clear_mon();
    drive_frame(1, 2, e_first, e_last);
    while (cyc + 1 < e_last + 3 + W) drive(1'b0, 1'b0, e);
    drive_frame(1, 2, e_first, e_last);
    idle(W + 5);
    nbad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].row !== exp_q[i].row || got_q[i].col !== exp_q[i].col) nbad++;
    n_total++;
    if (got_q.size() !== 2 * W * H || nbad !== 0)
      $display("FAIL b2b_events: %0d valid_o with %0d misplaced, required %0d with 0", got_q.size(), nbad, 2 * W * H);
    else n_pass++;
    n_total++;
    if (fo_cnt !== 2 || err_first !== -1) $display("FAIL b2b_frame_o: %0d frame_o err_at %0d, required 2/-1", fo_cnt, err_first);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int e, e_first, e_last, nbad;
    clear_mon();
    drive(1'b1, 1'b1, e);
    for (int c = 1; c < W; c++) drive(1'b1, 1'b0, e);
    drive(1'b0, 1'b0, e);
    drive(1'b1, 1'b0, e);
    drive(1'b1, 1'b0, e);
    @(negedge clock);
    valid_i = 1'b0;
    reset = 1'b0;
    #1;
    n_total++;
    if ({pix_we, lb_addr, adv, lb_rot, ctr_col, ctr_row, brd_left, brd_right, brd_top, brd_bot,
         valid_o, frame_o, busy} !== '0)
      $display("FAIL midrst_async: outputs not zero right after reset (adv=%b valid_o=%b busy=%b)", adv, valid_o, busy);
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    clear_mon();
    repeat (3) drive(1'b1, 1'b0, e);
    idle(2);
    n_total++;
    if (we_q.size() !== 0 || busy_first !== -1 || got_q.size() !== 0)
      $display("FAIL midrst_ignore: pix_we=%0d busy_at=%0d valid_o=%0d, required 0/-1/0", we_q.size(), busy_first, got_q.size());
    else n_pass++;
    clear_mon();
    drive_frame(2, 1, e_first, e_last);
    idle(W + 5);
    nbad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].row !== exp_q[i].row || got_q[i].col !== exp_q[i].col) nbad++;
    n_total++;
    if (got_q.size() !== W * H || nbad !== 0 || fo_cnt !== 1 || err_first !== -1)
      $display("FAIL midrst_frame: %0d valid_o %0d misplaced %0d frame_o err_at %0d, required %0d/0/1/-1",
               got_q.size(), nbad, fo_cnt, err_first, W * H);
    else n_pass++;
  endtask

  task automatic test_no_blank();
    int e, e_bad;
    do_reset();
    clear_mon();
    drive(1'b1, 1'b1, e);
    for (int c = 1; c < W; c++) drive(1'b1, 1'b0, e);
    drive(1'b1, 1'b0, e_bad);
    idle(3);
    n_total++;
    if (err_first !== e_bad || err !== 1'b1)
      $display("FAIL noblank_err: err first at %0d now %b, required %0d and 1", err_first, err, e_bad);
    else n_pass++;
    n_total++;
    if (we_q.size() !== W) $display("FAIL noblank_we: %0d pix_we, required %0d", we_q.size(), W);
    else n_pass++;
    n_total++;
    if (rot_q.size() !== 1 || (rot_q.size() == 1 && rot_q[0] !== e_bad))
      $display("FAIL noblank_rot: %0d lb_rot pulses, required 1 at %0d", rot_q.size(), e_bad);
    else n_pass++;
  endtask

  task automatic test_frame_restart();
    int e, e_first, e_last, nbad;
    do_reset();
    clear_mon();
    drive(1'b1, 1'b1, e);
    for (int c = 1; c < W; c++) drive(1'b1, 1'b0, e);
    drive(1'b0, 1'b0, e);
    drive(1'b1, 1'b0, e);
    drive(1'b1, 1'b0, e);
    idle(2);
    clear_mon();
    drive_frame(2, 2, e_first, e_last);
    idle(W + 5);
    n_total++;
    if (err_first !== e_first) $display("FAIL restart_err: err first at %0d, required %0d", err_first, e_first);
    else n_pass++;
    nbad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].row !== exp_q[i].row || got_q[i].col !== exp_q[i].col) nbad++;
    n_total++;
    if (got_q.size() !== W * H || nbad !== 0 || fo_cnt !== 1 || busy_last !== e_last + 2 + W)
      $display("FAIL restart_frame: %0d valid_o %0d misplaced %0d frame_o busy_last %0d, required %0d/0/1/%0d",
               got_q.size(), nbad, fo_cnt, busy_last, W * H, e_last + 2 + W);
    else n_pass++;
  endtask

  task automatic test_flush_valid();
    int e, e_first, e_last, e_fv, nbad, nbot;
    do_reset();
    clear_mon();
    drive_frame(1, 1, e_first, e_last);
    drive(1'b0, 1'b0, e);
    drive(1'b1, 1'b0, e_fv);
    idle(W + 4);
    n_total++;
    if (err_first !== e_fv) $display("FAIL flushv_err: err first at %0d, required %0d", err_first, e_fv);
    else n_pass++;
    nbad = 0; nbot = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].row !== exp_q[i].row || got_q[i].col !== exp_q[i].col) nbad++;
    foreach (got_q[i]) if (got_q[i].row == H - 1) nbot++;
    n_total++;
    if (got_q.size() !== W * H || nbad !== 0 || nbot !== W)
      $display("FAIL flushv_frame: %0d valid_o %0d misplaced %0d bottom, required %0d/0/%0d",
               got_q.size(), nbad, nbot, W * H, W);
    else n_pass++;
    n_total++;
    if (we_q.size() !== W * H + W || busy_last !== e_last + 2 + W)
      $display("FAIL flushv_we: %0d pix_we busy_last %0d, required %0d/%0d", we_q.size(), busy_last, W * H + W, e_last + 2 + W);
    else n_pass++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    clear_mon();
    test_reset();
    test_clean_frame();
    test_borders();
    test_back_to_back();
    test_reset_mid_run();
    test_no_blank();
    test_frame_restart();
    test_flush_valid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
